// File: rtl/onehot_event_arbiter.sv
// Synchronises and debounces N push-button lines, queues each rising edge as a pending event,
// and presents pending events one at a time as a one-hot vector with a valid/ready handshake.
//
// state   | meaning
// IDLE    | nothing presented; loads the lowest pending line, if there is one
// PRESENT | event_onehot/event_valid held until event_ready
module onehot_event_arbiter #(
  parameter int N        = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] event_onehot,
  output logic         event_valid,
  input  logic         event_ready,
  output logic         overrun
);

  localparam int CNT_W = $clog2(DEBOUNCE);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     s1_q, s1_d;
  logic [N-1:0]     s2_q, s2_d;
  logic [N-1:0]     stable_q, stable_d;
  logic [N-1:0]     stable_dly_q, stable_dly_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     onehot_q, onehot_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  logic [N-1:0]     rise;
  logic [N-1:0]     lowest;
  logic [N-1:0]     clr;

  always_comb begin
    s1_d         = btn_raw;
    s2_d         = s1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    rise   = stable_q & ~stable_dly_q;
    // Two's-complement trick isolates the lowest set bit of pending.
    lowest = pending_q & (~pending_q + N'(1));

    clr      = '0;
    state_d  = state_q;
    onehot_d = onehot_q;
    case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          onehot_d = lowest;
          clr      = lowest;
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        if (event_ready) begin
          onehot_d = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        onehot_d = '0;
        state_d  = IDLE;
      end
    endcase

    // A new edge on a line being served in this cycle survives as a fresh event.
    pending_d = (pending_q & ~clr) | rise;
    overrun_d = overrun_q | (|(rise & pending_q & ~clr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s1_q         <= '0;
      s2_q         <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      pending_q    <= '0;
      onehot_q     <= '0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      pending_q    <= pending_d;
      onehot_q     <= onehot_d;
      overrun_q    <= overrun_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign event_onehot = onehot_q;
  assign event_valid  = (state_q == PRESENT);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_onehot_event_arbiter.sv
// Directed bench for onehot_event_arbiter: reset, debounce latency, glitch rejection,
// priority with bubble, backpressure, overrun and reset mid-handshake.
module tb_onehot_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn_raw;
  logic [7:0] event_onehot;
  logic       event_valid;
  logic       event_ready;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  onehot_event_arbiter #(.N(8), .DEBOUNCE(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .event_onehot (event_onehot),
    .event_valid  (event_valid),
    .event_ready  (event_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] oh);
    check({tag, ".valid"}, 32'(event_valid), 32'(v));
    check({tag, ".onehot"}, 32'(event_onehot), 32'(oh));
  endtask

  task automatic do_reset(input logic [7:0] b);
    rst     = 1'b1;
    btn_raw = b;
    tick();
    tick();
    check_out("reset", 1'b0, 8'h00);
    check("reset.overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    btn_raw     = 8'h00;
    event_ready = 1'b1;

    // 1: reset with all buttons held, then all eight events drain lowest-first
    do_reset(8'hFF);
    ticks(7);
    check_out("t1.pre", 1'b0, 8'h00);
    for (int j = 0; j < 16; j++) begin
      tick();
      if (j % 2 == 0) check_out("t1.drain", 1'b1, 8'(1 << (j / 2)));
      else            check_out("t1.bubble", 1'b0, 8'h00);
    end
    check("t1.overrun", 32'(overrun), 32'd0);
    btn_raw = 8'h00;
    for (int j = 0; j < 12; j++) begin
      tick();
      check("t1.release", 32'(event_valid), 32'd0);
    end

    // 2: single press, latency 8 edges, one-cycle event, no repeat while held
    do_reset(8'h00);
    btn_raw = 8'h08;
    ticks(7);
    check_out("t2.pre", 1'b0, 8'h00);
    tick();
    check_out("t2.event", 1'b1, 8'h08);
    for (int j = 0; j < 20; j++) begin
      tick();
      check("t2.norepeat", 32'(event_valid), 32'd0);
    end

    // 3: 3-cycle glitch on line 2 is rejected
    do_reset(8'h00);
    btn_raw = 8'h04;
    ticks(3);
    btn_raw = 8'h00;
    for (int j = 0; j < 20; j++) begin
      tick();
      check("t3.glitch", 32'(event_valid), 32'd0);
    end
    check("t3.overrun", 32'(overrun), 32'd0);

    // 4: simultaneous lines 3 and 5 -> 08, bubble, 20
    do_reset(8'h00);
    btn_raw = 8'h28;
    ticks(8);
    check_out("t4.first", 1'b1, 8'h08);
    tick();
    check_out("t4.bubble", 1'b0, 8'h00);
    tick();
    check_out("t4.second", 1'b1, 8'h20);
    tick();
    check_out("t4.done", 1'b0, 8'h00);

    // 5: backpressure holds 01 stable; after accept, 08 follows the bubble
    do_reset(8'h00);
    event_ready = 1'b0;
    btn_raw     = 8'h09;
    ticks(8);
    check_out("t5.first", 1'b1, 8'h01);
    for (int j = 0; j < 20; j++) begin
      tick();
      check_out("t5.hold", 1'b1, 8'h01);
    end
    event_ready = 1'b1;
    tick();
    check_out("t5.accept", 1'b0, 8'h00);
    tick();
    check_out("t5.next", 1'b1, 8'h08);
    tick();
    check_out("t5.done", 1'b0, 8'h00);

    // 6: line 1 stalled on the output; line 0 pulses twice -> overrun, sticky until rst
    do_reset(8'h00);
    event_ready = 1'b0;
    btn_raw     = 8'h02;
    ticks(8);
    check_out("t6.stall", 1'b1, 8'h02);
    btn_raw = 8'h03;
    ticks(10);
    btn_raw = 8'h02;
    ticks(10);
    check("t6.one_pending", 32'(overrun), 32'd0);
    btn_raw = 8'h03;
    ticks(10);
    check("t6.overrun", 32'(overrun), 32'd1);
    btn_raw     = 8'h02;
    event_ready = 1'b1;
    tick();
    check_out("t6.accept", 1'b0, 8'h00);
    tick();
    check_out("t6.merged", 1'b1, 8'h01);
    event_ready = 1'b0;
    ticks(5);
    check_out("t6.merged_hold", 1'b1, 8'h01);
    check("t6.sticky", 32'(overrun), 32'd1);

    // reset mid-handshake drops the presented event
    do_reset(8'h00);
    event_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      check("t6.after_rst", 32'(event_valid), 32'd0);
    end
    check("t6.overrun_clr", 32'(overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
